// File: rtl/shift_scheduler_pkg.sv
// Shared types and sizing for the shift scheduler and its round-robin arbiter.
package shift_scheduler_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int DEPTH_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    FIN  = 2'd3
  } state_e;

  function automatic logic [1:0] onehotToIdx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/shift_scheduler_rr.sv
// Four-way round-robin pick: first active request at or above ptr, modulo 4.
module rr_arbiter4
  import shift_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);

  logic [1:0] idx;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr_i + 2'(i);
      if (!valid_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_scheduler.sv
// Walking-one sweep engine shared by four requesters; one sweep up to the
// requested depth and back down, then a one-cycle done pulse to the owner.
module shift_scheduler
  import shift_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DEPTH_W-1:0] num,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic [DATA_W-1:0]     shift_out,
  output logic [1:0]            state,
  output logic [DEPTH_W-1:0]    pos
);

  state_e               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 busy_q;
  logic [DATA_W-1:0]    shift_q;
  logic [DEPTH_W-1:0]   pos_q;
  logic [DEPTH_W-1:0]   tgt_q;
  logic [1:0]           ptr_q;

  logic [NUM_REQ-1:0]   pick;
  logic                 pickValid;
  logic [1:0]           pickIdx;
  logic [DEPTH_W-1:0]   depth_d;

  rr_arbiter4 u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .valid_o (pickValid)
  );

  assign pickIdx = onehotToIdx(pick);

  always_comb begin
    depth_d = num[2:0];
    case (pickIdx)
      2'd1:    depth_d = num[5:3];
      2'd2:    depth_d = num[8:6];
      2'd3:    depth_d = num[11:9];
      default: depth_d = num[2:0];
    endcase
  end

  // req/num are only looked at in IDLE, so a running sweep always finishes on its latched depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      shift_q <= '0;
      pos_q   <= '0;
      tgt_q   <= '0;
      ptr_q   <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            grant_q <= pick;
            tgt_q   <= depth_d;
            shift_q <= 8'h01;
            pos_q   <= '0;
            ptr_q   <= pickIdx + 2'd1;
            busy_q  <= 1'b1;
            if (depth_d == '0) begin
              state_q <= FIN;
              done_q  <= pick;
            end else begin
              state_q <= UP;
              done_q  <= '0;
            end
          end
        end
        UP: begin
          shift_q <= shift_q << 1;
          pos_q   <= pos_q + 3'd1;
          if (pos_q + 3'd1 == tgt_q) state_q <= DOWN;
        end
        DOWN: begin
          shift_q <= shift_q >> 1;
          pos_q   <= pos_q - 3'd1;
          if (pos_q == 3'd1) begin
            state_q <= FIN;
            done_q  <= grant_q;
          end
        end
        FIN: begin
          state_q <= IDLE;
          grant_q <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          shift_q <= '0;
          pos_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign shift_out = shift_q;
  assign state     = state_q;
  assign pos       = pos_q;

endmodule

// File: tb/tb_shift_scheduler.sv
// Directed bench for shift_scheduler: sweeps, zero/max depth, contention,
// mid-sweep reset and late input changes, each step checked against hand values.
module tb_shift_scheduler;
  import shift_scheduler_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] num;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  shift_out;
  logic [1:0]  state;
  logic [2:0]  pos;

  int total = 0;
  int bad   = 0;

  shift_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .num       (num),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .shift_out (shift_out),
    .state     (state),
    .pos       (pos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic stepClock(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [11:0] n);
    req = r;
    num = n;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] g, input logic [3:0] d,
                          input logic [1:0] st, input logic [7:0] s, input logic [2:0] p);
    checkOutput({tag, ".grant"}, 32'(grant), 32'(g));
    checkOutput({tag, ".done"}, 32'(done), 32'(d));
    checkOutput({tag, ".state"}, 32'(state), 32'(st));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(st != 2'd0));
    checkOutput({tag, ".shift"}, 32'(shift_out), 32'(s));
    checkOutput({tag, ".pos"}, 32'(pos), 32'(p));
  endtask

  // Full sweep of depth n>0 for one-hot owner g, starting from an IDLE cycle;
  // lateReq/lateNum are applied right after the grant edge to prove they are ignored.
  task automatic runSweep(input string tag, input logic [3:0] g, input int n,
                          input logic [3:0] lateReq, input logic [11:0] lateNum);
    stepClock(1);
    checkAll({tag, ".grant"}, g, 4'b0, 2'd1, 8'h01, 3'd0);
    applyStimulus(lateReq, lateNum);
    for (int i = 1; i <= n; i++) begin
      stepClock(1);
      checkAll($sformatf("%s.up%0d", tag, i), g, 4'b0, (i == n) ? 2'd2 : 2'd1,
               8'h01 << i, 3'(i));
    end
    for (int j = n - 1; j >= 1; j--) begin
      stepClock(1);
      checkAll($sformatf("%s.dn%0d", tag, j), g, 4'b0, 2'd2, 8'h01 << j, 3'(j));
    end
    stepClock(1);
    checkAll({tag, ".fin"}, g, g, 2'd3, 8'h01, 3'd0);
    stepClock(1);
    checkAll({tag, ".exit"}, 4'b0, 4'b0, 2'd0, 8'h00, 3'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(4'b0000, 12'h000);
    #2;
    checkAll("reset", 4'b0, 4'b0, 2'd0, 8'h00, 3'd0);
    stepClock(2);
    checkAll("reset.held", 4'b0, 4'b0, 2'd0, 8'h00, 3'd0);
    rst_n = 1'b1;
    stepClock(1);
    checkAll("idle", 4'b0, 4'b0, 2'd0, 8'h00, 3'd0);

    $display("[TB] single sweep depth 3");
    applyStimulus(4'b0001, 12'h003);
    runSweep("single", 4'b0001, 3, 4'b0000, 12'h003);

    $display("[TB] zero depth");
    applyStimulus(4'b0100, 12'h000);
    stepClock(1);
    checkAll("zero.fin", 4'b0100, 4'b0100, 2'd3, 8'h01, 3'd0);
    applyStimulus(4'b0000, 12'h000);
    stepClock(1);
    checkAll("zero.exit", 4'b0, 4'b0, 2'd0, 8'h00, 3'd0);

    $display("[TB] reset mid-sweep");
    applyStimulus(4'b0100, 12'h0C0);
    stepClock(1);
    checkAll("rst.grant", 4'b0100, 4'b0, 2'd1, 8'h01, 3'd0);
    stepClock(3);
    checkAll("rst.down", 4'b0100, 4'b0, 2'd2, 8'h08, 3'd3);
    rst_n = 1'b0;
    #1;
    checkAll("rst.async", 4'b0, 4'b0, 2'd0, 8'h00, 3'd0);
    stepClock(1);
    checkAll("rst.nodone", 4'b0, 4'b0, 2'd0, 8'h00, 3'd0);
    rst_n = 1'b1;
    applyStimulus(4'b1010, 12'h000);
    stepClock(1);
    checkAll("rst.regrant", 4'b0010, 4'b0010, 2'd3, 8'h01, 3'd0);
    applyStimulus(4'b0000, 12'h000);
    stepClock(1);
    checkAll("rst.exit", 4'b0, 4'b0, 2'd0, 8'h00, 3'd0);

    $display("[TB] contention, all depths 1");
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b1111, 12'h249);
    runSweep("cont0", 4'b0001, 1, 4'b1111, 12'h249);
    runSweep("cont1", 4'b0010, 1, 4'b1111, 12'h249);
    runSweep("cont2", 4'b0100, 1, 4'b1111, 12'h249);
    runSweep("cont3", 4'b1000, 1, 4'b1111, 12'h249);
    runSweep("cont4", 4'b0001, 1, 4'b0000, 12'h000);

    $display("[TB] max depth");
    applyStimulus(4'b1000, 12'hE00);
    runSweep("max", 4'b1000, 7, 4'b0000, 12'h000);

    $display("[TB] late change during UP");
    applyStimulus(4'b0001, 12'h002);
    runSweep("late", 4'b0001, 2, 4'b0000, 12'hFFF);
    stepClock(2);
    checkAll("late.idle", 4'b0, 4'b0, 2'd0, 8'h00, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_scheduler.md
SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports SHALL be named clk and rst_n.
REQ-002 The port list SHALL be exactly as follows (name, direction, width, meaning):
  clk        input   1   rising-edge clock
  rst_n      input   1   async active-low reset
  req        input   4   level request per requester r=0..3
  num        input   12  sweep depth per requester; num[3r+2:3r] = depth of requester r
  grant      output  4   one-hot owner of the sweep engine; 0 when idle
  done       output  4   one-hot, one-cycle completion pulse to the owner
  busy       output  1   high whenever state != IDLE
  shift_out  output  8   walking-one datapath output
  state      output  2   IDLE=0, UP=1, DOWN=2, FIN=3
  pos        output  3   current bit index of the walking one

Function
REQ-003 All outputs SHALL be registered; there SHALL be no combinational path from req or num to any output.
REQ-004 In IDLE with req!=0, the block SHALL pick a requester g by round-robin on the next clk edge, searching from pointer ptr upward modulo 4.
REQ-005 On that edge the block SHALL set grant to one-hot g, latch tgt=num[3g+2:3g], set shift_out=8'h01 and pos=0, and set ptr=(g+1) mod 4.
REQ-006 On the grant edge, the next state SHALL be FIN if tgt==0, else UP.
REQ-007 Each UP cycle SHALL shift shift_out left by 1 and increment pos; when pos+1==tgt, the next state SHALL be DOWN.
REQ-008 Each DOWN cycle SHALL shift shift_out right by 1 and decrement pos; when pos-1==0, the next state SHALL be FIN.
REQ-009 done[g] SHALL be set to 1 on the edge that enters FIN and cleared on the next edge; shift_out SHALL equal 8'h01 during FIN.
REQ-010 The edge leaving FIN SHALL set state=IDLE, grant=0, done=0, shift_out=8'h00 and pos=0.
REQ-011 IDLE SHALL last at least one cycle between consecutive sweeps; no back-to-back grants.
REQ-012 For depth N, the sweep from the grant edge to the FIN exit SHALL take exactly 2N+2 cycles, and shift_out SHALL step 01,02,...,2^N,...,02,01.
REQ-013 Depth 7 SHALL reach shift_out=8'h80 with no overflow; pos SHALL never wrap.
REQ-014 req and num SHALL be sampled only in IDLE; changes during UP, DOWN or FIN SHALL be ignored, with no abort.
REQ-015 A requester that holds req after its done pulse SHALL be re-eligible only after the other active requesters, per round-robin.
REQ-016 busy SHALL equal (state!=IDLE) and SHALL be updated on the same edge as state.

Reset
REQ-017 While rst_n=0, the block SHALL force state=IDLE, grant=0, done=0, busy=0, shift_out=0, pos=0, tgt=0 and ptr=0, regardless of clk.
REQ-018 Reset mid-sweep SHALL abort the sweep with no done pulse; the first grant after release SHALL search from requester 0.

Structure
REQ-019 A shared package SHALL hold the state enum (IDLE/UP/DOWN/FIN), NUM_REQ=4, DATA_W=8 and DEPTH_W=3.
REQ-020 The round-robin choice SHALL be a sub-module, rr_arbiter4, with inputs req and ptr and outputs a one-hot pick and a valid flag; the FSM and datapath SHALL stay in shift_scheduler.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - Single sweep: req=0001, num[2:0]=3 -> shift_out 01,02,04,08,04,02,01; done[0] high in the 01/FIN cycle; 8 cycles from grant to IDLE.
  - Zero depth: req=0100, num[8:6]=0 -> grant=0100 with shift_out=01 and state=FIN for one cycle; done[2] pulses; then IDLE.
  - Contention: req=1111 held, all depths 1 -> grants in order 0001,0010,0100,1000,0001; each sweep 4 cycles plus 1 IDLE cycle.
  - Max depth: req=1000, num[11:9]=7 -> shift_out peaks at 8'h80 on the 7th UP edge; 16 cycles total; pos peaks at 7.
  - Reset mid-sweep: rst_n=0 during DOWN -> all outputs 0 immediately with no done; after release, req=1010 grants 0010 first.
  - Late change: num changed and req dropped during UP -> sweep completes with the latched tgt and done still pulses.
